// File: rtl/mul_4bits_acc_if.sv
// Bundle of the accumulator's handshake and data signals.
//
// Handshake rule, used on both sides: a beat transfers on a rising clock edge
// where valid and ready are both 1. The sender holds its data stable while valid
// is high and not yet taken. The receiver may raise or drop ready freely.
//
// Signals:
//   clr        master->slave  sync clear of partial sum and held result
//   in_valid   master->slave  prod is valid
//   in_ready   slave->master  slave accepts prod this cycle
//   prod       master->slave  8-bit unsigned product
//   out_valid  slave->master  sum/ovf are valid
//   out_ready  master->slave  downstream takes the result
//   sum        slave->master  ACC_W-bit accumulated result
//   ovf        slave->master  the group overflowed ACC_W bits
interface mul_4bits_acc_if #(
  parameter int ACC_W = 10
);
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       prod;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum;
  logic             ovf;

  modport master (
    output clr, in_valid, prod, out_ready,
    input  in_ready, out_valid, sum, ovf
  );

  modport slave (
    input  clr, in_valid, prod, out_ready,
    output in_ready, out_valid, sum, ovf
  );
endinterface

// File: rtl/mul_4bits_acc.sv
// Accumulate stage of a small MAC datapath. Sums N_TERMS consecutive 8-bit
// products taken through a valid/ready handshake. Emits one ACC_W-bit result per
// group, together with an overflow flag, on an output valid/ready handshake.
//
// Parameters:
//   N_TERMS  products summed per result (2..255)
//   ACC_W    accumulator/result width (>= 8)
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        mul_4bits_acc_if.slave: clr, in_valid/in_ready/prod,
//              out_valid/out_ready/sum/ovf
//   state_dbg  current FSM state (0 = ACC, 1 = HOLD)
// Build option:
//   SATURATE_EN  when defined, the accumulator clamps at 2^ACC_W-1 on overflow.
//                Otherwise it wraps. In both builds ovf reports the overflow.
module mul_4bits_acc #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_4bits_acc_if.slave bus,
  output logic           state_dbg
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [7:0] LAST = 8'(N_TERMS - 1);

  state_t           state, state_nx;
  logic             run;       // low until the first clock after reset release
  logic [7:0]       cnt;
  logic [ACC_W-1:0] acc;
  logic             ovf_g;     // sticky overflow within the current group
  logic [ACC_W-1:0] sum_q;
  logic             ovf_q;

  logic             accept;
  logic             first;
  logic             last;
  logic [ACC_W:0]   prod_x;
  logic [ACC_W:0]   add_w;
  logic             carry;
  logic [ACC_W-1:0] total;

  assign bus.in_ready  = run & (state == ST_ACC) & ~bus.clr;
  assign bus.out_valid = (state == ST_HOLD);
  assign bus.sum       = sum_q;
  assign bus.ovf       = ovf_q;
  assign state_dbg     = state;

  assign accept = bus.in_valid & bus.in_ready;
  assign first  = (cnt == 8'd0);
  assign last   = (cnt == LAST);
  assign prod_x = (ACC_W + 1)'(bus.prod);

  // One adder, ACC_W+1 bits wide. The top bit is the carry out of the ACC_W-bit
  // accumulator. The first term of a group starts from zero, so it cannot carry.
  always_comb begin
    add_w = (first ? '0 : {1'b0, acc}) + prod_x;
    carry = add_w[ACC_W];
`ifdef SATURATE_EN
    // Once the accumulator is clamped, each later nonzero add carries again.
    // So the value stays clamped until the group ends.
    total = carry ? '1 : add_w[ACC_W-1:0];
`else
    total = add_w[ACC_W-1:0];
`endif
  end

  always_comb begin
    state_nx = state;
    if (bus.clr) begin
      state_nx = ST_ACC;
    end else begin
      case (state)
        ST_ACC:  if (accept && last) state_nx = ST_HOLD;
        ST_HOLD: if (bus.out_ready)  state_nx = ST_ACC;
        default: state_nx = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
      run   <= 1'b0;
      cnt   <= 8'd0;
      acc   <= '0;
      ovf_g <= 1'b0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      run   <= 1'b1;
      state <= state_nx;
      if (bus.clr) begin
        // Drop the partial group. sum/ovf keep their last values.
        cnt   <= 8'd0;
        acc   <= '0;
        ovf_g <= 1'b0;
      end else if (accept) begin
        if (last) begin
          sum_q <= total;
          ovf_q <= (ovf_g & ~first) | carry;
          cnt   <= 8'd0;
          acc   <= '0;
          ovf_g <= 1'b0;
        end else begin
          cnt   <= cnt + 8'd1;
          acc   <= total;
          ovf_g <= (ovf_g & ~first) | carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_4bits_acc.sv
module tb_mul_4bits_acc;

  logic clk;
  logic rst_n;
  logic st4, st8;

  mul_4bits_acc_if #(.ACC_W(10)) if4 ();
  mul_4bits_acc_if #(.ACC_W(10)) if8 ();

  mul_4bits_acc #(.N_TERMS(4), .ACC_W(10)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4), .state_dbg(st4)
  );

  mul_4bits_acc #(.N_TERMS(8), .ACC_W(10)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8), .state_dbg(st8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // scoreboard: {ovf, sum}
  logic [10:0] exp_q[$];

  typedef struct packed {
    logic [3:0][7:0] p;
    logic [9:0]      sum;
    logic            ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic ir(input bit big);
    return big ? if8.in_ready : if4.in_ready;
  endfunction

  function automatic logic ov(input bit big);
    return big ? if8.out_valid : if4.out_valid;
  endfunction

  function automatic int sm(input bit big);
    return big ? int'(if8.sum) : int'(if4.sum);
  endfunction

  function automatic int of(input bit big);
    return big ? int'(if8.ovf) : int'(if4.ovf);
  endfunction

  // driver: called at a falling edge, returns at the falling edge after the accept
  task automatic send(input bit big, input logic [7:0] p);
    int n = 0;
    if (big) begin if8.in_valid = 1'b1; if8.prod = p; end
    else     begin if4.in_valid = 1'b1; if4.prod = p; end
    #1;
    while (!ir(big) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("send_ready", int'(ir(big)), 1);
    @(negedge clk);
    if (big) if8.in_valid = 1'b0; else if4.in_valid = 1'b0;
  endtask

  // receiver: wait for a result, compare against the scoreboard, hand it off
  task automatic recv(input bit big);
    int n = 0;
    logic [10:0] e;
    while (!ov(big) && n < 100) begin
      @(negedge clk); n++;
    end
    check("recv_valid", int'(ov(big)), 1);
    check("sb_nonempty", exp_q.size(), (exp_q.size() == 0) ? 1 : exp_q.size());
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 11'd0;
    check("recv_sum", sm(big), int'(e[9:0]));
    check("recv_ovf", of(big), int'(e[10]));
    if (big) if8.out_ready = 1'b1; else if4.out_ready = 1'b1;
    @(negedge clk);
    if (big) if8.out_ready = 1'b0; else if4.out_ready = 1'b0;
    check("recv_drop", int'(ov(big)), 0);
  endtask

  logic [6:0] gap_pat;

  initial begin
    vecs[0] = '{p: {8'd18, 8'd0, 8'd21, 8'd225},   sum: 10'd264,  ovf: 1'b0};
    vecs[1] = '{p: {8'd1, 8'd1, 8'd1, 8'd1},       sum: 10'd4,    ovf: 1'b0};
    vecs[2] = '{p: {8'd255, 8'd255, 8'd255, 8'd255}, sum: 10'd1020, ovf: 1'b0};
    vecs[3] = '{p: {8'd0, 8'd255, 8'd255, 8'd255}, sum: 10'd765,  ovf: 1'b0};
    vecs[4] = '{p: {8'd0, 8'd0, 8'd0, 8'd0},       sum: 10'd0,    ovf: 1'b0};

    rst_n = 1'b0;
    if4.clr = 1'b0; if4.in_valid = 1'b0; if4.prod = 8'd0; if4.out_ready = 1'b0;
    if8.clr = 1'b0; if8.in_valid = 1'b0; if8.prod = 8'd0; if8.out_ready = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(if4.in_ready), 0);
    check("rst_out_valid", int'(if4.out_valid), 0);
    check("rst_sum", int'(if4.sum), 0);
    check("rst_ovf", int'(if4.ovf), 0);
    check("rst_state", int'(st4), 0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_low", int'(if4.in_ready), 0);
    @(negedge clk);
    check("rel_in_ready_high", int'(if4.in_ready), 1);

    // table-driven groups, back-to-back products
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 4; k++) send(1'b0, vecs[v].p[k]);
      check("latency_valid", int'(if4.out_valid), 1);
      check("state_hold", int'(st4), 1);
      exp_q.push_back({vecs[v].ovf, vecs[v].sum});
      recv(1'b0);
    end

    // reset mid-group with a nonzero held sum from the last group... load one first
    for (int k = 0; k < 4; k++) send(1'b0, 8'd9);
    exp_q.push_back({1'b0, 10'd36});
    recv(1'b0);
    send(1'b0, 8'd5);
    send(1'b0, 8'd5);
    rst_n = 1'b0;
    #1;
    check("t1_out_valid", int'(if4.out_valid), 0);
    check("t1_sum", int'(if4.sum), 0);
    check("t1_ovf", int'(if4.ovf), 0);
    check("t1_in_ready", int'(if4.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) send(1'b0, 8'd1);
    exp_q.push_back({1'b0, 10'd4});
    recv(1'b0);

    // backpressure in HOLD while the next group's products are offered
    send(1'b0, 8'd225); send(1'b0, 8'd21); send(1'b0, 8'd0); send(1'b0, 8'd18);
    for (int c = 0; c < 5; c++) begin
      if4.in_valid = 1'b1;
      if4.prod = 8'd99;
      @(negedge clk);
      check("t3_sum_hold", int'(if4.sum), 264);
      check("t3_in_ready", int'(if4.in_ready), 0);
      check("t3_out_valid", int'(if4.out_valid), 1);
    end
    if4.in_valid = 1'b0;
    exp_q.push_back({1'b0, 10'd264});
    recv(1'b0);
    check("t3_ready_back", int'(if4.in_ready), 1);
    send(1'b0, 8'd1); send(1'b0, 8'd2); send(1'b0, 8'd3); send(1'b0, 8'd4);
    exp_q.push_back({1'b0, 10'd10});
    recv(1'b0);

    // gaps in in_valid
    gap_pat = 7'b1011001;  // applied LSB first: 1,0,0,1,1,0,1
    for (int i = 0; i < 7; i++) begin
      if4.in_valid = gap_pat[i];
      if4.prod = 8'd225;
      @(negedge clk);
      if (i < 6) check("t4_early_valid", int'(if4.out_valid), 0);
    end
    if4.in_valid = 1'b0;
    check("t4_valid", int'(if4.out_valid), 1);
    exp_q.push_back({1'b0, 10'd900});
    recv(1'b0);

    // overflow on the 8-term instance, then a clean group
    for (int k = 0; k < 8; k++) send(1'b1, 8'd225);
`ifdef SATURATE_EN
    exp_q.push_back({1'b1, 10'd1023});
`else
    exp_q.push_back({1'b1, 10'd776});
`endif
    recv(1'b1);
    for (int k = 0; k < 8; k++) send(1'b1, 8'd100);
    exp_q.push_back({1'b0, 10'd800});
    recv(1'b1);

    // clr mid-group
    send(1'b0, 8'd50);
    send(1'b0, 8'd50);
    if4.clr = 1'b1;
    if4.in_valid = 1'b1;
    if4.prod = 8'd200;
    #1;
    check("t6_clr_ready", int'(if4.in_ready), 0);
    @(negedge clk);
    if4.clr = 1'b0;
    if4.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) send(1'b0, 8'd10);
    exp_q.push_back({1'b0, 10'd40});
    recv(1'b0);

    // clr in HOLD discards the held result
    for (int k = 0; k < 4; k++) send(1'b0, 8'd7);
    check("t6_hold_valid", int'(if4.out_valid), 1);
    if4.clr = 1'b1;
    @(negedge clk);
    if4.clr = 1'b0;
    check("t6_discard", int'(if4.out_valid), 0);
    check("t6_sum_kept", int'(if4.sum), 28);
    for (int k = 0; k < 4; k++) send(1'b0, 8'd3);
    exp_q.push_back({1'b0, 10'd12});
    recv(1'b0);

    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
